// File: rtl/eo_detector.sv
// Registered even/odd classifier with bit parity and saturating
// per-class sample counters for statistics/CSR readback.
module eo_detector #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     num,
    input  logic                 in_valid,
    input  logic                 clr_cnt,
    output logic                 y,
    output logic                 odd,
    output logic                 parity,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] even_count,
    output logic [CNT_WIDTH-1:0] odd_count,
    output logic                 even_sat,
    output logic                 odd_sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    function automatic logic is_even(input logic [WIDTH-1:0] v);
        return ~v[0];
    endfunction

    logic                 y_q, y_d;
    logic                 odd_q, odd_d;
    logic                 parity_q, parity_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] even_count_q, even_count_d;
    logic [CNT_WIDTH-1:0] odd_count_q, odd_count_d;
    logic                 even_sat_q, even_sat_d;
    logic                 odd_sat_q, odd_sat_d;
    logic                 sample_even;

    assign sample_even = is_even(num);

    always_comb begin
        y_d          = y_q;
        odd_d        = odd_q;
        parity_d     = parity_q;
        out_valid_d  = out_valid_q;
        even_count_d = even_count_q;
        odd_count_d  = odd_count_q;
        even_sat_d   = even_sat_q;
        odd_sat_d    = odd_sat_q;

        // num is only looked at when in_valid is high, so X/Z while idle is harmless
        if (in_valid) begin
            y_d         = sample_even;
            odd_d       = ~sample_even;
            parity_d    = ^num;
            out_valid_d = 1'b1;
        end

        if (clr_cnt) begin
            even_count_d = '0;
            odd_count_d  = '0;
            even_sat_d   = 1'b0;
            odd_sat_d    = 1'b0;
        end else if (in_valid) begin
            if (sample_even) begin
                if (even_count_q != CNT_MAX) begin
                    even_count_d = even_count_q + CNT_ONE;
                end
            end else begin
                if (odd_count_q != CNT_MAX) begin
                    odd_count_d = odd_count_q + CNT_ONE;
                end
            end
            even_sat_d = even_sat_q | (even_count_d == CNT_MAX);
            odd_sat_d  = odd_sat_q | (odd_count_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q          <= 1'b0;
            odd_q        <= 1'b0;
            parity_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            even_count_q <= '0;
            odd_count_q  <= '0;
            even_sat_q   <= 1'b0;
            odd_sat_q    <= 1'b0;
        end else begin
            y_q          <= y_d;
            odd_q        <= odd_d;
            parity_q     <= parity_d;
            out_valid_q  <= out_valid_d;
            even_count_q <= even_count_d;
            odd_count_q  <= odd_count_d;
            even_sat_q   <= even_sat_d;
            odd_sat_q    <= odd_sat_d;
        end
    end

    assign y          = y_q;
    assign odd        = odd_q;
    assign parity     = parity_q;
    assign out_valid  = out_valid_q;
    assign even_count = even_count_q;
    assign odd_count  = odd_count_q;
    assign even_sat   = even_sat_q;
    assign odd_sat    = odd_sat_q;

endmodule

// File: tb/tb_eo_detector.sv
// Bench for eo_detector: three instances (default, 2-bit counters,
// 1-bit samples) against a behavioural model plus literal checks.
module tb_eo_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] num = '0;
    logic       in_valid = 1'b0;
    logic       clr_cnt = 1'b0;

    always #5 clk = ~clk;

    logic        a_y, a_odd, a_par, a_ov, a_es, a_os;
    logic [15:0] a_ec, a_oc;
    logic        b_y, b_odd, b_par, b_ov, b_es, b_os;
    logic [1:0]  b_ec, b_oc;
    logic        c_y, c_odd, c_par, c_ov, c_es, c_os;
    logic [15:0] c_ec, c_oc;

    eo_detector #(.WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .num(num), .in_valid(in_valid),
        .clr_cnt(clr_cnt), .y(a_y), .odd(a_odd), .parity(a_par),
        .out_valid(a_ov), .even_count(a_ec), .odd_count(a_oc),
        .even_sat(a_es), .odd_sat(a_os));

    eo_detector #(.WIDTH(8), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .num(num), .in_valid(in_valid),
        .clr_cnt(clr_cnt), .y(b_y), .odd(b_odd), .parity(b_par),
        .out_valid(b_ov), .even_count(b_ec), .odd_count(b_oc),
        .even_sat(b_es), .odd_sat(b_os));

    eo_detector #(.WIDTH(1), .CNT_WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .num(num[0]), .in_valid(in_valid),
        .clr_cnt(clr_cnt), .y(c_y), .odd(c_odd), .parity(c_par),
        .out_valid(c_ov), .even_count(c_ec), .odd_count(c_oc),
        .even_sat(c_es), .odd_sat(c_os));

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    bit m_started = 0;
    int m_y, m_par, m_par1, m_ov;
    int m_ev, m_od;
    int m_ev2, m_od2;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1;
            m_y = 0; m_par = 0; m_par1 = 0; m_ov = 0;
            m_ev = 0; m_od = 0; m_ev2 = 0; m_od2 = 0;
        end else if (m_started) begin
            if (in_valid) begin
                m_y    = (num % 2 == 0) ? 1 : 0;
                m_par  = $countones(num) % 2;
                m_par1 = num % 2;
                m_ov   = 1;
            end
            if (clr_cnt) begin
                m_ev = 0; m_od = 0; m_ev2 = 0; m_od2 = 0;
            end else if (in_valid) begin
                if (num % 2 == 0) begin
                    m_ev  = (m_ev < 65535) ? m_ev + 1 : m_ev;
                    m_ev2 = (m_ev2 < 3) ? m_ev2 + 1 : m_ev2;
                end else begin
                    m_od  = (m_od < 65535) ? m_od + 1 : m_od;
                    m_od2 = (m_od2 < 3) ? m_od2 + 1 : m_od2;
                end
            end
        end
        #1;
        if (m_started) begin
            chk("a_y", a_y, m_y);
            chk("a_odd", a_odd, m_ov & (1 - m_y));
            chk("a_par", a_par, m_par);
            chk("a_ov", a_ov, m_ov);
            chk("a_ec", a_ec, m_ev);
            chk("a_oc", a_oc, m_od);
            chk("a_es", a_es, m_ev == 65535);
            chk("a_os", a_os, m_od == 65535);
            chk("b_y", b_y, m_y);
            chk("b_ec", b_ec, m_ev2);
            chk("b_oc", b_oc, m_od2);
            chk("b_es", b_es, m_ev2 == 3);
            chk("b_os", b_os, m_od2 == 3);
            chk("c_y", c_y, m_y);
            chk("c_odd", c_odd, m_ov & (1 - m_y));
            chk("c_par", c_par, m_par1);
            chk("c_ec", c_ec, m_ev);
            chk("c_oc", c_oc, m_od);
        end
    end

    task automatic drive(input bit r, input bit v, input int n, input bit c);
        @(negedge clk);
        rst = r; in_valid = v; num = 8'(n); clr_cnt = c;
    endtask

    task automatic settle();
        @(negedge clk);
        rst = 0; in_valid = 0; clr_cnt = 0;
    endtask

    int seq[7]   = '{0, 1, 2, 3, 10, 255, 128};
    int exp_y[7] = '{1, 0, 1, 0, 1, 0, 1};
    int exp_p[7] = '{0, 1, 1, 0, 0, 0, 1};

    initial begin
        // Reset then idle
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("lit_rst_y", a_y, 0);
        chk("lit_rst_ov", a_ov, 0);
        chk("lit_rst_ec", a_ec, 0);
        chk("lit_rst_oc", a_oc, 0);

        // Directed sequence, one sample per cycle
        for (int i = 0; i < 7; i++) begin
            rst = 0; in_valid = 1; num = 8'(seq[i]); clr_cnt = 0;
            @(negedge clk);
            chk("lit_seq_y", a_y, exp_y[i]);
            chk("lit_seq_par", a_par, exp_p[i]);
        end
        in_valid = 0;
        chk("lit_seq_ec", a_ec, 4);
        chk("lit_seq_oc", a_oc, 3);

        // Hold after an odd sample
        drive(0, 1, 3, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 2, 0);
        @(negedge clk);
        chk("lit_hold_y", a_y, 0);
        chk("lit_hold_ov", a_ov, 1);
        chk("lit_hold_ec", a_ec, 4);
        chk("lit_hold_oc", a_oc, 4);

        // Saturation on the 2-bit instance
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 2 * i, 0);
        settle();
        chk("lit_sat_ec", b_ec, 3);
        chk("lit_sat_es", b_es, 1);
        chk("lit_sat_oc", b_oc, 0);
        chk("lit_sat_os", b_os, 0);

        // Clear colliding with a sample
        drive(0, 1, 7, 1);
        settle();
        chk("lit_clr_y", a_y, 0);
        chk("lit_clr_odd", a_odd, 1);
        chk("lit_clr_ec", a_ec, 0);
        chk("lit_clr_oc", a_oc, 0);
        chk("lit_clr_bes", b_es, 0);

        // Reset mid-stream drops the sample
        drive(0, 1, 6, 0);
        drive(1, 1, 4, 0);
        settle();
        chk("lit_mrst_ov", a_ov, 0);
        chk("lit_mrst_y", a_y, 0);
        chk("lit_mrst_ec", a_ec, 0);
        drive(0, 1, 5, 0);
        settle();
        chk("lit_mrst_y5", a_y, 0);
        chk("lit_mrst_oc", a_oc, 1);
        chk("lit_mrst_w1p", c_par, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 255)),
                  $urandom_range(0, 49) == 0);
        end
        settle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
